// File: rtl/ws2812b_receiver.sv
// WS2812B pixel receiver model: decodes the pulse-width-coded NZR stream and captures
// the first 24 bits of each frame as a GRB word. Later bits are forwarded downstream.
// The captured word is latched to grbOut when a reset code (long low) is seen.
`timescale 1ns/1ps

module ws2812b_receiver #(
  parameter int unsigned T1_THRESH    = 60,
  parameter int unsigned MAX_HIGH     = 150,
  parameter int unsigned RESET_CYCLES = 28000,
  parameter int unsigned CNT_W        = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dataIn,
  output logic        dataOut,
  output logic [23:0] grbOut,
  output logic        colorValid,
  output logic        frameErr,
  output logic        synced
);

  localparam logic [CNT_W-1:0] CntMax   = '1;
  localparam logic [CNT_W-1:0] T1Thresh = CNT_W'(T1_THRESH);
  // Terminal counts fire on the cycle the counter reaches its limit, i.e. the
  // MAX_HIGH-th high cycle or the RESET_CYCLES-th low cycle.
  localparam logic [CNT_W-1:0] HiLast   = CNT_W'(MAX_HIGH - 1);
  localparam logic [CNT_W-1:0] LoLast   = CNT_W'(RESET_CYCLES - 1);

  typedef enum logic [1:0] {
    StSync,
    StIdle,
    StHigh,
    StLow
  } state_e;

  // Synchronizer and edge detection
  logic din_meta_q, din_s_q, din_prev_q;
  logic rise, fall;

  // Pulse-width counters
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] lo_cnt_q, lo_cnt_d;
  logic             hi_tc, lo_tc, bit_val;

  // Frame decode state
  state_e      state_q;
  logic [4:0]  bit_cnt_q;
  logic [23:0] shreg_q;
  logic        fwd_en_q;

  // Registered outputs
  logic        data_out_q;
  logic [23:0] grb_q;
  logic        color_valid_q;
  logic        frame_err_q;
  logic        synced_q;

  // Two-flop synchronizer plus one delayed copy for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      din_meta_q <= 1'b0;
      din_s_q    <= 1'b0;
      din_prev_q <= 1'b0;
    end else begin
      din_meta_q <= dataIn;
      din_s_q    <= din_meta_q;
      din_prev_q <= din_s_q;
    end
  end

  assign rise = din_s_q & ~din_prev_q;
  assign fall = ~din_s_q & din_prev_q;

  // Saturating high/low width counters; each clears on the edge that ends its level
  always_comb begin
    hi_cnt_d = hi_cnt_q;
    lo_cnt_d = lo_cnt_q;
    if (din_s_q) begin
      hi_cnt_d = (hi_cnt_q == CntMax) ? hi_cnt_q : hi_cnt_q + 1'b1;
      if (rise) begin
        lo_cnt_d = '0;
      end
    end else begin
      lo_cnt_d = (lo_cnt_q == CntMax) ? lo_cnt_q : lo_cnt_q + 1'b1;
      if (fall) begin
        hi_cnt_d = '0;
      end
    end
  end

  // Counter state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_cnt_q <= '0;
      lo_cnt_q <= '0;
    end else begin
      hi_cnt_q <= hi_cnt_d;
      lo_cnt_q <= lo_cnt_d;
    end
  end

  // On a fall hi_cnt_q holds the full high width of the pulse just ended
  assign bit_val = (hi_cnt_q >= T1Thresh);
  assign hi_tc   = din_s_q & (hi_cnt_q == HiLast);
  // Needs din_s low, so it can never coincide with a rise
  assign lo_tc   = ~din_s_q & (lo_cnt_q == LoLast);

  // Frame decoder FSM with registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StSync;
      bit_cnt_q     <= 5'd0;
      shreg_q       <= 24'h000000;
      fwd_en_q      <= 1'b0;
      grb_q         <= 24'h000000;
      color_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      synced_q      <= 1'b0;
    end else begin
      color_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      case (state_q)
        StSync: begin
          // Pulses are ignored until a full reset code has been observed
          if (lo_tc) begin
            synced_q <= 1'b1;
            state_q  <= StIdle;
          end
        end
        StIdle: begin
          if (rise) begin
            state_q <= StHigh;
          end
        end
        StHigh: begin
          if (fall) begin
            if (bit_cnt_q < 5'd24) begin
              shreg_q <= {shreg_q[22:0], bit_val};
            end
            if (bit_cnt_q != 5'd25) begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
            end
            // Bit 24 just completed: everything after it belongs downstream
            if (bit_cnt_q == 5'd23) begin
              fwd_en_q <= 1'b1;
            end
            state_q <= StLow;
          end else if (hi_tc) begin
            frame_err_q <= 1'b1;
            bit_cnt_q   <= 5'd0;
            synced_q    <= 1'b0;
            fwd_en_q    <= 1'b0;
            state_q     <= StSync;
          end
        end
        StLow: begin
          if (rise) begin
            state_q <= StHigh;
          end else if (lo_tc) begin
            if (bit_cnt_q >= 5'd24) begin
              grb_q         <= shreg_q;
              color_valid_q <= 1'b1;
            end else if (bit_cnt_q != 5'd0) begin
              frame_err_q <= 1'b1;
            end
            bit_cnt_q <= 5'd0;
            fwd_en_q  <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: begin
          state_q <= StSync;
        end
      endcase
    end
  end

  // Forwarded stream: synchronized input delayed one more flop, gated by fwd_en
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_q <= 1'b0;
    end else begin
      data_out_q <= fwd_en_q & din_s_q;
    end
  end

  assign dataOut    = data_out_q;
  assign grbOut     = grb_q;
  assign colorValid = color_valid_q;
  assign frameErr   = frame_err_q;
  assign synced     = synced_q;

endmodule

// File: tb/tb_ws2812b_receiver.sv
// Bench for ws2812b_receiver: random NZR frames against a frame-level reference model,
// with expected colour/error events and forwarded pulses checked by a separate monitor.
`timescale 1ns/1ps

module tb_ws2812b_receiver;

  localparam int unsigned T1   = 60;
  localparam int unsigned MAXH = 150;
  localparam int unsigned RSTC = 1500;
  localparam int unsigned CW   = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        data_in = 1'b0;
  logic        data_out;
  logic [23:0] grb_out;
  logic        color_valid;
  logic        frame_err;
  logic        synced;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ws2812b_receiver #(
    .T1_THRESH   (T1),
    .MAX_HIGH    (MAXH),
    .RESET_CYCLES(RSTC),
    .CNT_W       (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .dataIn    (data_in),
    .dataOut   (data_out),
    .grbOut    (grb_out),
    .colorValid(color_valid),
    .frameErr  (frame_err),
    .synced    (synced)
  );

  typedef struct {
    bit          is_err;
    logic [23:0] grb;
  } ev_t;

  typedef struct {
    longint rise_t;
    int     width;
  } fwd_t;

  ev_t  ev_q[$];
  fwd_t fwd_q[$];

  // Reference model: frame-level view of the pixel
  bit          m_synced = 1'b0;
  bit          m_bits[$];
  logic [23:0] m_grb = 24'h000000;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Low period: a reset code applies the latch rule or (re)synchronizes
  task automatic low_phase(input int lo);
    logic [23:0] g;
    if (lo >= int'(RSTC)) begin
      if (m_synced) begin
        if (m_bits.size() >= 24) begin
          for (int i = 0; i < 24; i++) g[23-i] = m_bits[i];
          ev_q.push_back('{1'b0, g});
          m_grb = g;
        end else if (m_bits.size() > 0) begin
          ev_q.push_back('{1'b1, 24'h000000});
        end
      end
      m_synced = 1'b1;
      m_bits.delete();
    end
    data_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  // One high pulse of hi cycles then lo cycles low; called right after a negedge
  task automatic pulse(input int hi, input int lo);
    if (m_synced) begin
      if (hi >= int'(MAXH)) begin
        ev_q.push_back('{1'b1, 24'h000000});
        m_synced = 1'b0;
        m_bits.delete();
      end else begin
        m_bits.push_back(hi >= int'(T1));
        if (m_bits.size() > 24) fwd_q.push_back('{longint'($time) + 30, hi});
      end
    end
    data_in = 1'b1;
    repeat (hi) @(negedge clk);
    check("synced at end of high", synced, m_synced);
    low_phase(lo);
  endtask

  function automatic int rand_hi(input bit b);
    return b ? int'($urandom_range(60, 140)) : int'($urandom_range(10, 59));
  endfunction

  task automatic send_word(input logic [23:0] v, input int n, input int last_lo, input bit fixed);
    bit b;
    int hi, lo;
    for (int i = 0; i < n; i++) begin
      b  = v[23-i];
      hi = fixed ? (b ? 80 : 40) : rand_hi(b);
      lo = fixed ? (b ? 45 : 85) : int'($urandom_range(20, 90));
      if (i == n - 1) lo = last_lo;
      pulse(hi, lo);
    end
  endtask

  task automatic send_rand(input int n, input int last_lo);
    for (int i = 0; i < n; i++) begin
      pulse(rand_hi(1'($urandom_range(0, 1))), (i == n - 1) ? last_lo : int'($urandom_range(20, 90)));
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents an event or a forwarded pulse
  logic   do_prev = 1'b0;
  bit     fwd_active = 1'b0;
  int     fwd_w = 0;
  fwd_t   fwd_cur;
  ev_t    ev_cur;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (color_valid) begin
          if (ev_q.size() == 0) fail_now("unexpected colorValid");
          else begin
            ev_cur = ev_q.pop_front();
            check("colorValid event kind", ev_cur.is_err, 1'b0);
            check("grbOut on colorValid", grb_out, ev_cur.grb);
          end
        end
        if (frame_err) begin
          if (ev_q.size() == 0) fail_now("unexpected frameErr");
          else begin
            ev_cur = ev_q.pop_front();
            check("frameErr event kind", ev_cur.is_err, 1'b1);
          end
        end
        if (data_out && !do_prev) begin
          if (fwd_q.size() == 0) fail_now("unexpected dataOut pulse");
          else begin
            fwd_cur    = fwd_q.pop_front();
            check("dataOut rise time", longint'($time), fwd_cur.rise_t);
            fwd_w      = 1;
            fwd_active = 1'b1;
          end
        end else if (data_out) begin
          fwd_w++;
        end else if (do_prev && fwd_active) begin
          check("dataOut pulse width", fwd_w, fwd_cur.width);
          fwd_active = 1'b0;
        end
      end
      do_prev = data_out;
    end
  end

  initial begin
    reset   = 1'b1;
    data_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset dataOut", data_out, 1'b0);
    check("reset grbOut", grb_out, 24'h000000);
    check("reset colorValid", color_valid, 1'b0);
    check("reset frameErr", frame_err, 1'b0);
    check("reset synced", synced, 1'b0);
    reset = 1'b0;
    low_phase(RSTC + 10);

    // Power-up frame with nominal widths
    send_word(24'hFF0000, 24, RSTC + 20, 1'b1);
    check("grbOut after power-up frame", grb_out, 24'hFF0000);

    // Chain forwarding: second word goes downstream
    send_word(24'h123456, 24, 60, 1'b0);
    send_word(24'hABCDEF, 24, RSTC + 20, 1'b0);
    check("grbOut after chain", grb_out, 24'h123456);

    // Short frame keeps the previous colour
    send_word(24'($urandom), 16, RSTC + 20, 1'b0);
    check("grbOut after short frame", grb_out, m_grb);

    // Malformed pulse mid-frame, ignored bits, then resync and a good frame
    send_word(24'($urandom), 8, 50, 1'b0);
    pulse(200, 60);
    send_word(24'($urandom), 10, RSTC + 20, 1'b0);
    send_word(24'($urandom), 24, RSTC + 20, 1'b0);

    // Threshold boundaries: 59 vs 60 high, 1499-cycle gap does not latch
    pulse(59, 50);
    pulse(60, 50);
    send_rand(22, RSTC - 1);
    pulse(80, RSTC + 20);
    check("grbOut after threshold frame", grb_out, m_grb);

    // Async reset at bit 12
    send_word(24'($urandom), 12, 50, 1'b0);
    data_in = 1'b1;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid-frame reset dataOut", data_out, 1'b0);
    check("mid-frame reset grbOut", grb_out, 24'h000000);
    check("mid-frame reset colorValid", color_valid, 1'b0);
    check("mid-frame reset frameErr", frame_err, 1'b0);
    check("mid-frame reset synced", synced, 1'b0);
    m_synced = 1'b0;
    m_bits.delete();
    m_grb = 24'h000000;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    data_in = 1'b0;
    repeat (50) @(negedge clk);
    send_word(24'($urandom), 11, RSTC + 20, 1'b0);
    send_word(24'($urandom), 24, RSTC + 20, 1'b0);
    check("grbOut after reset recovery", grb_out, m_grb);

    // Random frame lengths, covering short, exact and forwarded frames
    for (int k = 0; k < 4; k++) begin
      send_rand(int'($urandom_range(1, 40)), RSTC + 20);
    end

    repeat (50) @(negedge clk);
    check("pending events", ev_q.size(), 0);
    check("pending forwarded pulses", fwd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
